// File: rtl/axis_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen_if
// AXI4-Stream bundle used by the pattern generator.
//   tdata  [DATA_WIDTH] : pattern beat (master -> slave)
//   tvalid              : beat valid   (master -> slave)
//   tready              : sink ready   (slave  -> master)
//   tlast               : last beat of each line (master -> slave)
//   tuser               : first beat of each frame (master -> slave)
// DATA_WIDTH must match the DATA_WIDTH of the attached generator.
// -----------------------------------------------------------------------------
interface axis_pattern_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/axis_pattern_gen.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen
// AXI4-Stream video-style test pattern source. Emits frames of
// FRAME_WIDTH x FRAME_HEIGHT beats while enable is high; a frame that has
// started is always completed.
//
// Parameters
//   DATA_WIDTH   : tdata width, 8..64
//   FRAME_WIDTH  : beats per line, 2..4095
//   FRAME_HEIGHT : lines per frame, 1..4095
//
// Ports
//   m_axis_aclk    : clock, rising edge
//   m_axis_aresetn : asynchronous active-low reset
//   enable         : level request to generate frames
//   mode           : 0 toggle, 1 count, 2 column ramp, 3 LFSR
//   seed           : pattern start value (sampled at frame start)
//   m_axis         : AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//   frame_done     : one-cycle pulse after the final beat of a frame is accepted
//   busy           : high while in RUN
//
// Build option
//   PATGEN_LFSR_EN : when defined, mode 3 is a Galois LFSR; otherwise mode 3
//                    behaves as mode 0 and no LFSR logic is built.
// -----------------------------------------------------------------------------
module axis_pattern_gen #(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  axis_pattern_gen_if.master    m_axis,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_reg;
  logic [XW-1:0]         x_reg, x_next;
  logic [YW-1:0]         y_reg, y_next;
  // Beat index within the frame; only its value modulo 2^DATA_WIDTH matters.
  logic [DATA_WIDTH-1:0] idx_reg, idx_next;
  logic [1:0]            mode_reg;
  logic [DATA_WIDTH-1:0] seed_reg;
  logic [DATA_WIDTH-1:0] tdata_reg;
  logic                  tvalid_reg;
  logic                  tlast_reg;
  logic                  tuser_reg;
  logic                  frame_done_reg;
  logic                  busy_reg;

  logic                  accept;
  logic                  frame_end;
  logic                  load_frame;
  logic [DATA_WIDTH-1:0] start_data;
  logic [DATA_WIDTH-1:0] adv_data;

`ifdef PATGEN_LFSR_EN
  // Maximal-length feedback polynomials; tap t maps to mask bit t-1 of a
  // right-shifting Galois register.
  function automatic logic [63:0] tap(input int t);
    return 64'd1 << (t - 1);
  endfunction

  function automatic logic [63:0] lfsr_poly(input int w);
    case (w)
      8:       lfsr_poly = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:       lfsr_poly = tap(9)  | tap(5);
      10:      lfsr_poly = tap(10) | tap(7);
      11:      lfsr_poly = tap(11) | tap(9);
      12:      lfsr_poly = tap(12) | tap(6)  | tap(4)  | tap(1);
      13:      lfsr_poly = tap(13) | tap(4)  | tap(3)  | tap(1);
      14:      lfsr_poly = tap(14) | tap(5)  | tap(3)  | tap(1);
      15:      lfsr_poly = tap(15) | tap(14);
      16:      lfsr_poly = tap(16) | tap(15) | tap(13) | tap(4);
      17:      lfsr_poly = tap(17) | tap(14);
      18:      lfsr_poly = tap(18) | tap(11);
      19:      lfsr_poly = tap(19) | tap(6)  | tap(2)  | tap(1);
      20:      lfsr_poly = tap(20) | tap(17);
      21:      lfsr_poly = tap(21) | tap(19);
      22:      lfsr_poly = tap(22) | tap(21);
      23:      lfsr_poly = tap(23) | tap(18);
      24:      lfsr_poly = tap(24) | tap(23) | tap(22) | tap(17);
      25:      lfsr_poly = tap(25) | tap(22);
      26:      lfsr_poly = tap(26) | tap(6)  | tap(2)  | tap(1);
      27:      lfsr_poly = tap(27) | tap(5)  | tap(2)  | tap(1);
      28:      lfsr_poly = tap(28) | tap(25);
      29:      lfsr_poly = tap(29) | tap(27);
      30:      lfsr_poly = tap(30) | tap(6)  | tap(4)  | tap(1);
      31:      lfsr_poly = tap(31) | tap(28);
      32:      lfsr_poly = tap(32) | tap(22) | tap(2)  | tap(1);
      33:      lfsr_poly = tap(33) | tap(20);
      34:      lfsr_poly = tap(34) | tap(27) | tap(2)  | tap(1);
      35:      lfsr_poly = tap(35) | tap(33);
      36:      lfsr_poly = tap(36) | tap(25);
      37:      lfsr_poly = tap(37) | tap(5)  | tap(4)  | tap(3) | tap(2) | tap(1);
      38:      lfsr_poly = tap(38) | tap(6)  | tap(5)  | tap(1);
      39:      lfsr_poly = tap(39) | tap(35);
      40:      lfsr_poly = tap(40) | tap(38) | tap(21) | tap(19);
      41:      lfsr_poly = tap(41) | tap(38);
      42:      lfsr_poly = tap(42) | tap(41) | tap(20) | tap(19);
      43:      lfsr_poly = tap(43) | tap(42) | tap(38) | tap(37);
      44:      lfsr_poly = tap(44) | tap(43) | tap(18) | tap(17);
      45:      lfsr_poly = tap(45) | tap(44) | tap(42) | tap(41);
      46:      lfsr_poly = tap(46) | tap(45) | tap(26) | tap(25);
      47:      lfsr_poly = tap(47) | tap(42);
      48:      lfsr_poly = tap(48) | tap(47) | tap(21) | tap(20);
      49:      lfsr_poly = tap(49) | tap(40);
      50:      lfsr_poly = tap(50) | tap(49) | tap(24) | tap(23);
      51:      lfsr_poly = tap(51) | tap(50) | tap(36) | tap(35);
      52:      lfsr_poly = tap(52) | tap(49);
      53:      lfsr_poly = tap(53) | tap(52) | tap(38) | tap(37);
      54:      lfsr_poly = tap(54) | tap(53) | tap(18) | tap(17);
      55:      lfsr_poly = tap(55) | tap(31);
      56:      lfsr_poly = tap(56) | tap(55) | tap(35) | tap(34);
      57:      lfsr_poly = tap(57) | tap(50);
      58:      lfsr_poly = tap(58) | tap(39);
      59:      lfsr_poly = tap(59) | tap(58) | tap(38) | tap(37);
      60:      lfsr_poly = tap(60) | tap(59);
      61:      lfsr_poly = tap(61) | tap(60) | tap(46) | tap(45);
      62:      lfsr_poly = tap(62) | tap(61) | tap(6)  | tap(5);
      63:      lfsr_poly = tap(63) | tap(62);
      default: lfsr_poly = tap(64) | tap(63) | tap(61) | tap(60);
    endcase
  endfunction

  localparam logic [DATA_WIDTH-1:0] LFSR_MASK = DATA_WIDTH'(lfsr_poly(DATA_WIDTH));

  logic [DATA_WIDTH-1:0] lfsr_reg;
  logic [DATA_WIDTH-1:0] lfsr_step;
  logic [DATA_WIDTH-1:0] lfsr_load;

  // An all-zero state would lock the LFSR, so a zero seed loads 1 instead.
  assign lfsr_load = (seed == '0) ? DATA_WIDTH'(1) : seed;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_lfsr
      assign lfsr_step[gi] = lfsr_reg[gi+1] ^ (LFSR_MASK[gi] & lfsr_reg[0]);
    end
  endgenerate
  assign lfsr_step[DATA_WIDTH-1] = LFSR_MASK[DATA_WIDTH-1] & lfsr_reg[0];
`endif

  always_comb begin
    accept    = tvalid_reg & m_axis.tready;
    frame_end = (x_reg == X_LAST) && (y_reg == Y_LAST);
    // A new frame is loaded from IDLE, or straight after the last beat when
    // enable is still high, so back-to-back frames have no gap cycle.
    load_frame = ((state_reg == IDLE) && enable) || (accept && frame_end && enable);

    idx_next = idx_reg + DATA_WIDTH'(1);
    if (x_reg == X_LAST) begin
      x_next = '0;
      y_next = (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
    end else begin
      x_next = x_reg + XW'(1);
      y_next = y_reg;
    end

    // Beat 0 of every mode except the LFSR is simply the seed.
    start_data = seed;
`ifdef PATGEN_LFSR_EN
    if (mode == 2'd3) start_data = lfsr_load;
`endif

    case (mode_reg)
      2'd1:    adv_data = seed_reg + idx_next;
      2'd2:    adv_data = seed_reg + DATA_WIDTH'(x_next);
`ifdef PATGEN_LFSR_EN
      2'd3:    adv_data = lfsr_step;
`endif
      default: adv_data = idx_next[0] ? ~seed_reg : seed_reg;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      idx_reg        <= '0;
      mode_reg       <= '0;
      seed_reg       <= '0;
      tdata_reg      <= '0;
      tvalid_reg     <= 1'b0;
      tlast_reg      <= 1'b0;
      tuser_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef PATGEN_LFSR_EN
      lfsr_reg       <= '0;
`endif
    end else begin
      frame_done_reg <= accept && frame_end;
      if (load_frame) begin
        state_reg  <= RUN;
        busy_reg   <= 1'b1;
        x_reg      <= '0;
        y_reg      <= '0;
        idx_reg    <= '0;
        mode_reg   <= mode;
        seed_reg   <= seed;
        tdata_reg  <= start_data;
        tvalid_reg <= 1'b1;
        tlast_reg  <= 1'b0;
        tuser_reg  <= 1'b1;
`ifdef PATGEN_LFSR_EN
        lfsr_reg   <= lfsr_load;
`endif
      end else if (accept && frame_end) begin
        state_reg  <= IDLE;
        busy_reg   <= 1'b0;
        x_reg      <= '0;
        y_reg      <= '0;
        idx_reg    <= '0;
        tdata_reg  <= '0;
        tvalid_reg <= 1'b0;
        tlast_reg  <= 1'b0;
        tuser_reg  <= 1'b0;
      end else if (accept) begin
        x_reg      <= x_next;
        y_reg      <= y_next;
        idx_reg    <= idx_next;
        tdata_reg  <= adv_data;
        tlast_reg  <= (x_next == X_LAST);
        tuser_reg  <= 1'b0;
`ifdef PATGEN_LFSR_EN
        lfsr_reg   <= lfsr_step;
`endif
      end
    end
  end

  assign m_axis.tdata  = tdata_reg;
  assign m_axis.tvalid = tvalid_reg;
  assign m_axis.tlast  = tlast_reg;
  assign m_axis.tuser  = tuser_reg;
  assign frame_done    = frame_done_reg;
  assign busy          = busy_reg;

endmodule
